// File: rtl/mcu_spi.sv
// SPI slave (mode 0) bridging the companion MCU to the OSD, HID and SD-card consumers.
// One chip-select assertion is one frame: a target byte, then payload bytes forwarded as strobes.
module mcu_spi #(
    parameter logic [7:0] HID_ID    = 8'd1,
    parameter logic [7:0] OSD_ID    = 8'd2,
    parameter logic [7:0] SDC_ID    = 8'd3,
    parameter logic [7:0] SIGNATURE = 8'h5C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_io_ss,
    input  logic       spi_io_clk,
    input  logic       spi_io_din,
    output logic       spi_io_dout,
    output logic       mcu_hid_strobe,
    output logic       mcu_osd_strobe,
    output logic       mcu_sdc_strobe,
    output logic       mcu_start,
    output logic [7:0] mcu_dout,
    input  logic [7:0] mcu_hid_din,
    input  logic [7:0] mcu_sdc_din
);

    typedef enum logic [1:0] {IDLE, TARGET, DATA} state_t;
    typedef enum logic [1:0] {TGT_NONE, TGT_HID, TGT_OSD, TGT_SDC} target_t;

    state_t     state;
    target_t    target;
    logic       ss_s1, ss_s2, ss_q;
    logic       sck_s1, sck_s2, sck_q;
    logic       din_s1, din_s2;
    logic [2:0] cnt;
    logic [7:0] rx_sr;
    logic [7:0] tx_sr;
    logic       first;
    logic       pend_valid;
    target_t    pend_tgt;
    logic       pend_start;
    logic [7:0] pend_byte;

    logic       ss_fall, sck_rise, sck_fall;
    logic [7:0] rx_byte;

    // Synchronisers reset low so a reset inside a frame (ss still low) cannot fake a new ss fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_s1  <= 1'b0;
            ss_s2  <= 1'b0;
            ss_q   <= 1'b0;
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_q  <= 1'b0;
            din_s1 <= 1'b0;
            din_s2 <= 1'b0;
        end else begin
            ss_s1  <= spi_io_ss;
            ss_s2  <= ss_s1;
            ss_q   <= ss_s2;
            sck_s1 <= spi_io_clk;
            sck_s2 <= sck_s1;
            sck_q  <= sck_s2;
            din_s1 <= spi_io_din;
            din_s2 <= din_s1;
        end
    end

    assign ss_fall     = ss_q & ~ss_s2;
    assign sck_rise    = sck_s2 & ~sck_q;
    assign sck_fall    = ~sck_s2 & sck_q;
    assign rx_byte     = {rx_sr[6:0], din_s2};
    assign spi_io_dout = tx_sr[7];

    function automatic target_t decode(input logic [7:0] b);
        if (b == HID_ID)      return TGT_HID;
        else if (b == OSD_ID) return TGT_OSD;
        else if (b == SDC_ID) return TGT_SDC;
        else                  return TGT_NONE;
    endfunction

    function automatic logic [7:0] reply(input target_t t, input logic [7:0] hid, input logic [7:0] sdc);
        case (t)
            TGT_HID: return hid;
            TGT_SDC: return sdc;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            target         <= TGT_NONE;
            cnt            <= 3'd0;
            rx_sr          <= 8'h00;
            tx_sr          <= 8'h00;
            first          <= 1'b0;
            pend_valid     <= 1'b0;
            pend_tgt       <= TGT_NONE;
            pend_start     <= 1'b0;
            pend_byte      <= 8'h00;
            mcu_hid_strobe <= 1'b0;
            mcu_osd_strobe <= 1'b0;
            mcu_sdc_strobe <= 1'b0;
            mcu_start      <= 1'b0;
            mcu_dout       <= 8'h00;
        end else begin
            mcu_hid_strobe <= pend_valid && (pend_tgt == TGT_HID);
            mcu_osd_strobe <= pend_valid && (pend_tgt == TGT_OSD);
            mcu_sdc_strobe <= pend_valid && (pend_tgt == TGT_SDC);
            mcu_start      <= pend_valid && pend_start;
            if (pend_valid) mcu_dout <= pend_byte;
            pend_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state  <= TARGET;
                        target <= TGT_NONE;
                        cnt    <= 3'd0;
                        first  <= 1'b0;
                        tx_sr  <= SIGNATURE;
                    end
                end
                TARGET, DATA: begin
                    if (sck_rise) begin
                        rx_sr <= rx_byte;
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (state == TARGET) begin
                                target <= decode(rx_byte);
                                first  <= 1'b1;
                                state  <= DATA;
                                tx_sr  <= reply(decode(rx_byte), mcu_hid_din, mcu_sdc_din);
                            end else begin
                                tx_sr <= reply(target, mcu_hid_din, mcu_sdc_din);
                                if (target != TGT_NONE) begin
                                    pend_valid <= 1'b1;
                                    pend_tgt   <= target;
                                    pend_start <= first;
                                    pend_byte  <= rx_byte;
                                end
                                first <= 1'b0;
                            end
                        end
                    // The fall right after the 8th rise must not shift out the freshly loaded reply MSB.
                    end else if (sck_fall && cnt != 3'd0) begin
                        tx_sr <= {tx_sr[6:0], 1'b0};
                    end
                    if (ss_s2) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mcu_spi.md
Name: mcu_spi

Overview:
SPI slave that receives framed byte streams from the BL616 companion MCU and routes them to on-chip consumers: OSD, HID and SD-card controller. Each frame is one chip-select assertion. The first byte selects the target; the following bytes are forwarded as strobe/start/data triplets, which the OSD consumes directly. Also returns reply bytes on MISO.

Parameters:
HID_ID, 8'd1, target byte selecting the HID port
OSD_ID, 8'd2, target byte selecting the OSD port
SDC_ID, 8'd3, target byte selecting the SD-card port
SIGNATURE, 8'h5C, byte shifted out on MISO during the target byte

Ports:
clk  in  1  system clock; must be >= 8x spi_io_clk
reset  in  1  synchronous, active-high
spi_io_ss  in  1  chip select, active-low, async to clk
spi_io_clk  in  1  SPI clock, mode 0, async to clk
spi_io_din  in  1  MOSI
spi_io_dout  out  1  MISO
mcu_hid_strobe  out  1  one-cycle byte-valid pulse for HID
mcu_osd_strobe  out  1  one-cycle byte-valid pulse for OSD
mcu_sdc_strobe  out  1  one-cycle byte-valid pulse for SDC
mcu_start  out  1  high with a strobe when the byte is the first after the target byte
mcu_dout  out  8  forwarded byte, valid while any strobe is high
mcu_hid_din  in  8  reply byte from HID
mcu_sdc_din  in  8  reply byte from SDC

Behaviour:
- Synchronisation: ss, clk and din each pass through a 2-FF synchroniser. Edges are detected on the synchronised SCK (rise/fall = current vs. previous synced value).
- Reset values: all strobes 0, mcu_start 0, mcu_dout 0, spi_io_dout 0, bit counter 0, target NONE, state IDLE.
- States:
  - IDLE: synced ss high.
  - TARGET: ss low, first byte being received.
  - DATA: target latched, payload bytes being received.
- Transitions:
  - IDLE -> TARGET on synced ss falling. The bit counter clears and the TX shift register loads SIGNATURE.
  - TARGET -> DATA after the 8th SCK rise. The received byte is compared to HID_ID, OSD_ID and SDC_ID; any other value latches target NONE. The first-byte flag is set.
  - Any state -> IDLE when synced ss is high.
- RX: on each synced SCK rise, shift din in MSB first and increment the 3-bit counter. The 8th rise wraps the counter to 0.
- Byte complete in DATA:
  - On the clk cycle after the 8th rise: mcu_dout = byte, the strobe of the latched target = 1 for exactly one cycle, mcu_start = first-byte flag.
  - The first-byte flag is then cleared.
  - Target NONE: no strobe, mcu_dout unchanged.
- The target byte itself never produces a strobe.
- Strobes are mutually exclusive. mcu_start is 0 whenever no strobe is high.
- TX:
  - MSB of the TX register is driven on spi_io_dout and shifted left on each synced SCK fall.
  - At each byte completion the TX register reloads: mcu_hid_din for target HID, mcu_sdc_din for SDC, 8'h00 for OSD/NONE. Inputs are sampled on the same cycle as the reload.
- Abort: synced ss rising mid-byte (counter != 0) discards the partial bits, produces no strobe, and returns to IDLE. A byte completing on the same cycle that ss rises is still delivered.
- Consecutive frames: the target is re-selected per frame, with no state carried across frames except mcu_dout.
- reset asserted mid-frame: immediate return to reset values. Subsequent SCK edges are ignored until the next ss falling edge.
- Latency: strobe pulse 4 to 5 clk cycles after the raw 8th SCK rising edge (2 sync + 1 edge detect + 1 register).

Test Plan:
- Frame ss low, bytes 02 01 01, ss high -> two mcu_osd_strobe pulses: dout=01 start=1, then dout=01 start=0. No HID/SDC strobes.
- Frame 02 02 05 AA 55 (OSD tile write) -> four OSD strobes: 02(start=1), 05, AA, 55, each exactly one clk wide.
- Frame 01 xx with mcu_hid_din=A7 -> MISO reads 5C during the target byte, A7 during the second byte; one HID strobe, start=1.
- Frame 07 11 22 (unknown target) -> no strobes at all; mcu_dout keeps its previous value.
- Frame 03 then 5 SCK bits then ss high, then new frame 02 03 -> no strobe from the aborted frame; next frame delivers OSD byte 03 with start=1.
- reset pulsed after 3 bits of the second byte in frame 02 ... -> outputs at reset values; later clocks with ss still low give no strobes until ss toggles high then low.
